vx_ti_hit_collector: RTL and testbench

//  Closest-hit reducer directly downstream of the T&I traversal FSM and its intersect unit. Per ray
//  it absorbs the stream of triangle-intersection results, keeps the nearest valid hit, and on

---
 rtl/vx_ti_hit_collector_if.sv | 50 +++++
 rtl/vx_ti_hit_collector.sv | 109 ++++++++++
 tb/tb_vx_ti_hit_collector.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/vx_ti_hit_collector_if.sv
// Closest-hit collector bus: start request, intersect results, response beat.
// slave = collector side, master = traversal/testbench side.
interface vx_ti_hit_collector_if #(
  parameter int TAG_WIDTH = 8,
  parameter int CNT_WIDTH = 16
);
  logic                 start_valid;
  logic                 start_ready;
  logic [TAG_WIDTH-1:0] start_tag;
  logic [31:0]          start_tmax;
  logic                 res_valid;
  logic                 res_ready;
  logic                 res_is_tri;
  logic                 res_hit;
  logic [31:0]          res_t;
  logic [31:0]          res_u;
  logic [31:0]          res_v;
  logic [31:0]          res_tri_idx;
  logic                 done;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [TAG_WIDTH-1:0] rsp_tag;
  logic                 rsp_hit;
  logic [31:0]          rsp_t;
  logic [31:0]          rsp_u;
  logic [31:0]          rsp_v;
  logic [31:0]          rsp_tri_idx;
  logic [CNT_WIDTH-1:0] rsp_tests;
  logic [CNT_WIDTH-1:0] rsp_hits;

  modport slave (
    input  start_valid, start_tag, start_tmax,
    input  res_valid, res_is_tri, res_hit,
    input  res_t, res_u, res_v, res_tri_idx,
    input  done, rsp_ready,
    output start_ready, res_ready, rsp_valid,
    output rsp_tag, rsp_hit, rsp_t, rsp_u, rsp_v,
    output rsp_tri_idx, rsp_tests, rsp_hits
  );

  modport master (
    output start_valid, start_tag, start_tmax,
    output res_valid, res_is_tri, res_hit,
    output res_t, res_u, res_v, res_tri_idx,
    output done, rsp_ready,
    input  start_ready, res_ready, rsp_valid,
    input  rsp_tag, rsp_hit, rsp_t, rsp_u, rsp_v,
    input  rsp_tri_idx, rsp_tests, rsp_hits
  );
endinterface

// File: rtl/vx_ti_hit_collector.sv
// Per-ray closest-hit reducer: keeps nearest valid hit, counts tests/hits.
// Ports: clk, reset (async active-low), bus (start/res/done in, rsp out).
module vx_ti_hit_collector #(
  parameter int          TAG_WIDTH = 8,
  parameter int          CNT_WIDTH = 16,
  parameter logic [31:0] T_MIN     = 32'h3727C5AC
) (
  input logic clk,
  input logic reset,
  vx_ti_hit_collector_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESP
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  state_t state;

  logic t_pos;
  logic t_nan;
  logic best_ok;
  logic accept;
  logic beat;

  // Non-negative fp32 order equals unsigned integer order.
  // A negative or NaN best distance blocks every hit.
  assign t_pos   = ~bus.res_t[31];
  assign t_nan   = (bus.res_t[30:23] == 8'hFF) &
                   (bus.res_t[22:0] != '0);
  assign best_ok = ~bus.rsp_t[31] &
                   ~((bus.rsp_t[30:23] == 8'hFF) &
                     (bus.rsp_t[22:0] != '0));
  assign beat    = bus.res_valid & bus.res_is_tri;
  assign accept  = beat & bus.res_hit & t_pos &
                   ~t_nan & best_ok &
                   (bus.res_t > T_MIN) &
                   (bus.res_t < bus.rsp_t);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      bus.start_ready <= 1'b1;
      bus.res_ready   <= 1'b0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_tag     <= '0;
      bus.rsp_hit     <= 1'b0;
      bus.rsp_t       <= '0;
      bus.rsp_u       <= '0;
      bus.rsp_v       <= '0;
      bus.rsp_tri_idx <= 32'hFFFF_FFFF;
      bus.rsp_tests   <= '0;
      bus.rsp_hits    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start_valid) begin
            state           <= ACCUM;
            bus.start_ready <= 1'b0;
            bus.res_ready   <= 1'b1;
            bus.rsp_tag     <= bus.start_tag;
            bus.rsp_hit     <= 1'b0;
            bus.rsp_t       <= bus.start_tmax;
            bus.rsp_u       <= '0;
            bus.rsp_v       <= '0;
            bus.rsp_tri_idx <= 32'hFFFF_FFFF;
            bus.rsp_tests   <= '0;
            bus.rsp_hits    <= '0;
          end
        end
        ACCUM: begin
          if (beat && !(&bus.rsp_tests))
            bus.rsp_tests <= bus.rsp_tests + CNT_ONE;
          if (accept) begin
            bus.rsp_hit     <= 1'b1;
            bus.rsp_t       <= bus.res_t;
            bus.rsp_u       <= bus.res_u;
            bus.rsp_v       <= bus.res_v;
            bus.rsp_tri_idx <= bus.res_tri_idx;
            if (!(&bus.rsp_hits))
              bus.rsp_hits <= bus.rsp_hits + CNT_ONE;
          end
          if (bus.done) begin
            state         <= RESP;
            bus.res_ready <= 1'b0;
            bus.rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state           <= IDLE;
            bus.rsp_valid   <= 1'b0;
            bus.start_ready <= 1'b1;
          end
        end
        default: begin
          state           <= IDLE;
          bus.start_ready <= 1'b1;
          bus.res_ready   <= 1'b0;
          bus.rsp_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vx_ti_hit_collector.sv
// Directed bench for vx_ti_hit_collector (CNT_WIDTH=4 instance).
// Drives the master modport signals, checks the response beat.
module tb_vx_ti_hit_collector;

  localparam int TW = 8;
  localparam int CW = 4;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  vx_ti_hit_collector_if #(.TAG_WIDTH(TW), .CNT_WIDTH(CW)) bus ();

  vx_ti_hit_collector #(
    .TAG_WIDTH(TW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic start(input logic [7:0] tag,
                       input logic [31:0] tmax);
    bus.start_valid = 1'b1;
    bus.start_tag   = tag;
    bus.start_tmax  = tmax;
    step();
    bus.start_valid = 1'b0;
  endtask

  task automatic res(input logic tri_b,
                     input logic hit,
                     input logic [31:0] t,
                     input logic [31:0] idx,
                     input logic dn);
    bus.res_valid   = 1'b1;
    bus.res_is_tri  = tri_b;
    bus.res_hit     = hit;
    bus.res_t       = t;
    bus.res_u       = t ^ 32'h1;
    bus.res_v       = t ^ 32'h2;
    bus.res_tri_idx = idx;
    bus.done        = dn;
    step();
    bus.res_valid = 1'b0;
    bus.done      = 1'b0;
  endtask

  task automatic finish_ray();
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
  endtask

  task automatic ack();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.start_valid = 1'b0;
    bus.start_tag   = '0;
    bus.start_tmax  = '0;
    bus.res_valid   = 1'b0;
    bus.res_is_tri  = 1'b0;
    bus.res_hit     = 1'b0;
    bus.res_t       = '0;
    bus.res_u       = '0;
    bus.res_v       = '0;
    bus.res_tri_idx = '0;
    bus.done        = 1'b0;
    bus.rsp_ready   = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    chk("rst_start_ready", 32'(bus.start_ready), 1);
    chk("rst_res_ready", 32'(bus.res_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_t", bus.rsp_t, 0);
    chk("rst_rsp_idx", bus.rsp_tri_idx, 32'hFFFF_FFFF);

    // 1: two improving hits
    start(8'd3, 32'h42C8_0000);
    chk("t1_res_ready", 32'(bus.res_ready), 1);
    chk("t1_start_ready", 32'(bus.start_ready), 0);
    res(1, 1, 32'h40A0_0000, 7, 0);
    res(1, 1, 32'h4000_0000, 9, 0);
    finish_ray();
    chk("t1_valid", 32'(bus.rsp_valid), 1);
    chk("t1_tag", 32'(bus.rsp_tag), 3);
    chk("t1_hit", 32'(bus.rsp_hit), 1);
    chk("t1_t", bus.rsp_t, 32'h4000_0000);
    chk("t1_u", bus.rsp_u, 32'h4000_0001);
    chk("t1_v", bus.rsp_v, 32'h4000_0002);
    chk("t1_idx", bus.rsp_tri_idx, 9);
    chk("t1_tests", 32'(bus.rsp_tests), 2);
    chk("t1_hits", 32'(bus.rsp_hits), 2);
    ack();
    chk("t1_start_ready", 32'(bus.start_ready), 1);
    chk("t1_valid_clr", 32'(bus.rsp_valid), 0);

    // 2: tie keeps first, farther rejected
    start(8'd5, 32'h4120_0000);
    res(1, 1, 32'h4080_0000, 1, 0);
    res(1, 1, 32'h4080_0000, 2, 0);
    res(1, 1, 32'h41A0_0000, 3, 0);
    finish_ray();
    chk("t2_idx", bus.rsp_tri_idx, 1);
    chk("t2_t", bus.rsp_t, 32'h4080_0000);
    chk("t2_hits", 32'(bus.rsp_hits), 1);
    chk("t2_tests", 32'(bus.rsp_tests), 3);
    ack();

    // 3: every result rejected
    start(8'd6, 32'h4120_0000);
    res(1, 1, 32'hBF80_0000, 11, 0);
    res(1, 1, 32'h7FC0_0000, 12, 0);
    res(1, 1, 32'h3586_37BD, 13, 0);
    res(1, 0, 32'h3F80_0000, 14, 0);
    res(0, 1, 32'h3F00_0000, 15, 0);
    finish_ray();
    chk("t3_hit", 32'(bus.rsp_hit), 0);
    chk("t3_t", bus.rsp_t, 32'h4120_0000);
    chk("t3_u", bus.rsp_u, 0);
    chk("t3_idx", bus.rsp_tri_idx, 32'hFFFF_FFFF);
    chk("t3_tests", 32'(bus.rsp_tests), 4);
    chk("t3_hits", 32'(bus.rsp_hits), 0);
    ack();

    // 3b: negative tmax blocks all hits
    start(8'd8, 32'hBF80_0000);
    res(1, 1, 32'h3F80_0000, 4, 0);
    finish_ray();
    chk("t3b_hit", 32'(bus.rsp_hit), 0);
    chk("t3b_t", bus.rsp_t, 32'hBF80_0000);
    ack();

    // 4: result with done, backpressure
    start(8'd4, 32'h42C8_0000);
    res(1, 1, 32'h4040_0000, 21, 1);
    chk("t4_valid", 32'(bus.rsp_valid), 1);
    chk("t4_t", bus.rsp_t, 32'h4040_0000);
    bus.start_valid = 1'b1;
    bus.start_tag   = 8'd9;
    bus.start_tmax  = 32'h3F80_0000;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_hold_valid", 32'(bus.rsp_valid), 1);
      chk("t4_hold_t", bus.rsp_t, 32'h4040_0000);
      chk("t4_hold_tag", 32'(bus.rsp_tag), 4);
      chk("t4_start_ready", 32'(bus.start_ready), 0);
    end
    bus.start_valid = 1'b0;
    ack();
    chk("t4_start_ready", 32'(bus.start_ready), 1);
    chk("t4_tag_kept", 32'(bus.rsp_tag), 4);
    chk("t4_res_ready", 32'(bus.res_ready), 0);

    // 5: test counter saturates at 15
    start(8'd10, 32'h42C8_0000);
    for (int i = 0; i < 20; i++)
      res(1, 0, 32'h3F80_0000, i, 0);
    finish_ray();
    chk("t5_tests", 32'(bus.rsp_tests), 15);
    chk("t5_hits", 32'(bus.rsp_hits), 0);
    ack();

    // 6: reset in the middle of a ray
    start(8'd12, 32'h42C8_0000);
    res(1, 1, 32'h4000_0000, 5, 0);
    bus.done = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(bus.rsp_valid), 0);
    chk("t6_res_ready", 32'(bus.res_ready), 0);
    chk("t6_t", bus.rsp_t, 0);
    chk("t6_idx", bus.rsp_tri_idx, 32'hFFFF_FFFF);
    chk("t6_hits", 32'(bus.rsp_hits), 0);
    chk("t6_tag", 32'(bus.rsp_tag), 0);
    step();
    bus.done = 1'b0;
    rst_n = 1'b1;
    step();
    chk("t6_valid_after", 32'(bus.rsp_valid), 0);
    chk("t6_start_ready", 32'(bus.start_ready), 1);
    start(8'd13, 32'h4120_0000);
    finish_ray();
    chk("t6_new_valid", 32'(bus.rsp_valid), 1);
    chk("t6_new_tag", 32'(bus.rsp_tag), 13);
    chk("t6_new_hit", 32'(bus.rsp_hit), 0);
    chk("t6_new_t", bus.rsp_t, 32'h4120_0000);
    chk("t6_new_tests", 32'(bus.rsp_tests), 0);
    ack();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
